inport_rx_fifo: RTL and testbench
=================================

# inport_rx_fifo

Clocked receive stage directly downstream of the LDL input port in the `wb_LDLinp_gpio` wrapper. It samples the port's arbitrated `valid` level in the local clock domain and captures the bundled data word on each new token. Captured words are buffered in a small FIFO and exposed to the Wishbone bus as data and status registers. An optional interrupt signals data available or overflow.

## Interface
- `DW`, 8, data word width
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `clk`  in  1  local clock; same clock drives the input port's `clk_inputport`
- `reset`  in  1  reset, synchronous, active-high
- `port_valid`  in  1  `valid` level from the input port; already mutex-arbitrated against `clk`, so no synchroniser
- `port_data`  in  DW  bundled data; stable whenever `port_valid`=1
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1  Wishbone classic slave controls
- `wb_adr_i`  in  2  word address
- `wb_dat_i`  in  DW  write data
- `wb_dat_o`  out  DW  read data
- `wb_ack_o`  out  1  single-cycle acknowledge
- `rx_overflow`  out  1  sticky overflow flag
- `irq_o`  out  1  interrupt (constant 0 when the feature is compiled out)

## Operation
- Token detect: `valid_q` <= `port_valid`. Push request = `port_valid & ~valid_q`, i.e. the rising edge only. A held-high `valid` yields exactly one push.
- Push writes `port_data` at `wr_ptr`, then increments. If the FIFO is full and no pop occurs in the same cycle, the word is dropped and `rx_overflow` is set.
- Pointers are log2(DEPTH)+1 bits. Full = MSBs differ and LSBs are equal. Empty = pointers equal. Count = `wr_ptr - rd_ptr`, modulo wrap.
- Register map:
  - 0 RX_DATA (R): returns the head word and pops. When empty it returns 0 and does not pop.
  - 1 STATUS (R): {overflow, full, ~empty, count} packed from bit 0 upward as count[log2(DEPTH):0], then not_empty, full, overflow. Upper bits read 0.
  - 2 CTRL (W): bit 0 = 1 clears `rx_overflow`.
  - 3 IRQ_EN (R/W): bit 0 enables the data interrupt, bit 1 enables the overflow interrupt. Present only with the macro; otherwise reads 0 and ignores writes.
- Writes to 0/1 and reads of 2 are acked with no effect; reads of 2 return 0.
- Push and pop in the same cycle both occur; count is unchanged. Push while full with a simultaneous pop is accepted.
- An overflow clear and a new overflow in the same cycle leave the flag set.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `rx_overflow`=0, `irq_o`=0, pointers=0, `valid_q`=0, IRQ_EN=0.
- Wishbone: `wb_ack_o`=1 in the cycle after `cyc & stb & ~wb_ack_o`. It stays high for exactly one cycle, so back-to-back accesses complete every other cycle.
- `wb_dat_o` is registered and valid with ack. The pop takes effect on the ack edge.
- Push latency: a word is visible in STATUS/RX_DATA 2 cycles after `port_valid` rises (1 cycle edge detect, 1 cycle write).
- `irq_o` is registered: (en[0] & ~empty) | (en[1] & overflow).
- Reset mid-access aborts: ack is dropped and FIFO contents are discarded. If `port_valid` is high at reset release, `valid_q`=0 makes it count as a new token.

## Configuration
- `INPORT_RX_IRQ_EN`
  - Defined: IRQ_EN register and `irq_o` logic are present.
  - Undefined: `irq_o` is tied to 0 and address 3 reads 0.

## Structure
- Shared package `ldl_gpio_pkg`:
  - Register address constants (`RX_DATA_ADR`, `STATUS_ADR`, `CTRL_ADR`, `IRQ_EN_ADR`).
  - STATUS bit positions.
- One sub-module: `rx_fifo`, a synchronous DEPTH×DW FIFO with push/pop/full/empty/count. The top level holds edge detect, registers and the Wishbone FSM (IDLE/ACK).

## Test plan
- Reset, then read STATUS → 0. Read RX_DATA → 0 and STATUS is still 0.
- Pulse `port_valid` with data 0xA5, then hold high 10 cycles → STATUS count=1, RX_DATA=0xA5, then count=0.
- Four tokens 0x01..0x04 then a fifth 0x05 → full=1, overflow=1, reads return 0x01..0x04 in order. Write CTRL=1 → overflow=0.
- With the FIFO full, a token arriving on the same edge as an RX_DATA pop → no overflow, count stays 4, new word read last.
- Wrap: 10 push/pop pairs of 0x10..0x19 → each read matches; pointers wrap without a false full or empty.
- With `INPORT_RX_IRQ_EN`: IRQ_EN=1, push one token → `irq_o`=1 within 3 cycles. Pop → `irq_o`=0 next cycle.

Source files
------------

// File: rtl/ldl_gpio_pkg.sv
// Shared definitions for the LDL GPIO receive path: register map, STATUS layout
// and the Wishbone slave state encoding.
package ldl_gpio_pkg;

   localparam logic [1:0] RX_DATA_ADR = 2'd0;
   localparam logic [1:0] STATUS_ADR  = 2'd1;
   localparam logic [1:0] CTRL_ADR    = 2'd2;
   localparam logic [1:0] IRQ_EN_ADR  = 2'd3;

   // STATUS flags sit just above the count field; offsets are from the count MSB.
   localparam int STATUS_NE_OFS   = 1;
   localparam int STATUS_FULL_OFS = 2;
   localparam int STATUS_OVF_OFS  = 3;

   localparam int IRQ_DATA_BIT = 0;
   localparam int IRQ_OVF_BIT  = 1;
   localparam int CTRL_CLR_BIT = 0;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_ACK  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/inport_rx_fifo_if.sv
// Wishbone classic slave bundle for the input-port receive registers.
interface inport_rx_fifo_if #(parameter int DW = 8);
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic          wb_we_i;
   logic [1:0]    wb_adr_i;
   logic [DW-1:0] wb_dat_i;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/inport_rx_fifo_rx_fifo.sv
// Synchronous DEPTH x DW FIFO with extra-MSB pointers; head word is read
// combinationally so a pop can return its data in the same cycle.
module rx_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [DW-1:0]              head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_reg [DEPTH];
   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign head    = mem_reg[rd_ptr_reg[AW-1:0]];
   // A pop frees the slot being written, so a full FIFO still accepts a push then.
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi)))
               mem_reg[gi] <= push_data;
         end
      end
   endgenerate
endmodule

// File: rtl/inport_rx_fifo.sv
// Receive stage behind the LDL input port: token edge detect, RX FIFO and Wishbone registers.
// Define INPORT_RX_IRQ_EN to build the IRQ_EN register and irq_o logic.
module inport_rx_fifo
   import ldl_gpio_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              port_valid,
   input  logic [DW-1:0]     port_data,
   inport_rx_fifo_if.slave   wb,
   output logic              rx_overflow,
   output logic              irq_o
);
   localparam int AW = $clog2(DEPTH);

   wb_state_t     state_reg;
   logic          valid_q_reg;
   logic          push_reg;
   logic [DW-1:0] push_data_reg;
   logic          ack_reg;
   logic [DW-1:0] dat_reg;
   logic          overflow_reg;

   logic [DW-1:0] head;
   logic          full;
   logic          empty;
   logic [AW:0]   count;

   logic          wb_req;
   logic          rd_req;
   logic          wr_req;
   logic          pop;
   logic          ovf_clr;
   logic          ovf_set;
   logic [DW-1:0] status_word;
   logic [DW-1:0] irq_en_word;
   logic [DW-1:0] rd_word;
   logic          unused_dat_bits;

   assign unused_dat_bits = ^wb.wb_dat_i[DW-1:1];

   // Only the rising edge of valid is a token; the word is written one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q_reg   <= 1'b0;
         push_reg      <= 1'b0;
         push_data_reg <= '0;
      end else begin
         valid_q_reg   <= port_valid;
         push_reg      <= port_valid & ~valid_q_reg;
         push_data_reg <= port_data;
      end
   end

   rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_reg),
      .push_data (push_data_reg),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   always_comb begin
      wb_req  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
      rd_req  = wb_req & ~wb.wb_we_i;
      wr_req  = wb_req & wb.wb_we_i;
      pop     = rd_req && (wb.wb_adr_i == RX_DATA_ADR) && !empty;
      ovf_clr = wr_req && (wb.wb_adr_i == CTRL_ADR) && wb.wb_dat_i[CTRL_CLR_BIT];
      ovf_set = push_reg & full & ~pop;

      status_word                        = '0;
      status_word[AW:0]                  = count;
      status_word[AW + STATUS_NE_OFS]    = ~empty;
      status_word[AW + STATUS_FULL_OFS]  = full;
      status_word[AW + STATUS_OVF_OFS]   = overflow_reg;

      rd_word = '0;
      case (wb.wb_adr_i)
         RX_DATA_ADR: rd_word = empty ? '0 : head;
         STATUS_ADR:  rd_word = status_word;
         IRQ_EN_ADR:  rd_word = irq_en_word;
         default:     rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= WB_IDLE;
         ack_reg      <= 1'b0;
         dat_reg      <= '0;
         overflow_reg <= 1'b0;
      end else begin
         // A clear and a new overflow in the same cycle leave the flag set.
         overflow_reg <= (overflow_reg & ~ovf_clr) | ovf_set;
         case (state_reg)
            WB_IDLE: begin
               ack_reg <= 1'b0;
               if (wb_req) begin
                  state_reg <= WB_ACK;
                  ack_reg   <= 1'b1;
                  if (rd_req) dat_reg <= rd_word;
               end
            end
            WB_ACK: begin
               state_reg <= WB_IDLE;
               ack_reg   <= 1'b0;
            end
            default: begin
               state_reg <= WB_IDLE;
               ack_reg   <= 1'b0;
            end
         endcase
      end
   end

`ifdef INPORT_RX_IRQ_EN
   logic [1:0] irq_en_reg;
   logic       irq_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en_reg <= 2'b00;
         irq_reg    <= 1'b0;
      end else begin
         if (wr_req && (wb.wb_adr_i == IRQ_EN_ADR))
            irq_en_reg <= wb.wb_dat_i[1:0];
         irq_reg <= (irq_en_reg[IRQ_DATA_BIT] & ~empty) |
                    (irq_en_reg[IRQ_OVF_BIT] & overflow_reg);
      end
   end

   always_comb begin
      irq_en_word      = '0;
      irq_en_word[1:0] = irq_en_reg;
   end
   assign irq_o = irq_reg;
`else
   assign irq_en_word = '0;
   assign irq_o       = 1'b0;
`endif

   assign wb.wb_ack_o = ack_reg;
   assign wb.wb_dat_o = dat_reg;
   assign rx_overflow = overflow_reg;
endmodule

// File: tb/tb_inport_rx_fifo.sv
// Directed bench for inport_rx_fifo: register map, token detect, overflow, wrap and reset.
module tb_inport_rx_fifo;
   logic       clk = 1'b0;
   logic       reset;
   logic       port_valid;
   logic [7:0] port_data;
   logic       rx_overflow;
   logic       irq_o;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] rd;

   inport_rx_fifo_if #(.DW(8)) wb_bus ();

   inport_rx_fifo #(.DW(8), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .port_valid  (port_valid),
      .port_data   (port_data),
      .wb          (wb_bus.slave),
      .rx_overflow (rx_overflow),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access; returns at the negedge where ack is seen, bus released there.
   task automatic wb_access(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                            output logic [7:0] rdat);
      int n = 0;
      @(negedge clk);
      wb_bus.wb_cyc_i = 1'b1;
      wb_bus.wb_stb_i = 1'b1;
      wb_bus.wb_we_i  = we;
      wb_bus.wb_adr_i = adr;
      wb_bus.wb_dat_i = wdat;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_bus.wb_ack_o && n < 8);
      check("ack", {31'd0, wb_bus.wb_ack_o}, 32'd1);
      rdat = wb_bus.wb_dat_o;
      wb_bus.wb_cyc_i = 1'b0;
      wb_bus.wb_stb_i = 1'b0;
      wb_bus.wb_we_i  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [7:0] exp);
      logic [7:0] d;
      wb_access(1'b0, adr, 8'h00, d);
      check(tag, {24'd0, d}, {24'd0, exp});
      $display("read  adr=%0d data=%02h expected=%02h", adr, d, exp);
   endtask

   task automatic wr(input logic [1:0] adr, input logic [7:0] wdat);
      logic [7:0] d;
      wb_access(1'b1, adr, wdat, d);
      $display("write adr=%0d data=%02h", adr, wdat);
   endtask

   task automatic token(input logic [7:0] d);
      @(negedge clk);
      port_valid = 1'b1;
      port_data  = d;
      @(negedge clk);
      port_valid = 1'b0;
      $display("token data=%02h", d);
   endtask

   initial begin
      reset           = 1'b1;
      port_valid      = 1'b0;
      port_data       = 8'h00;
      wb_bus.wb_cyc_i = 1'b0;
      wb_bus.wb_stb_i = 1'b0;
      wb_bus.wb_we_i  = 1'b0;
      wb_bus.wb_adr_i = 2'd0;
      wb_bus.wb_dat_i = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, wb_bus.wb_ack_o}, 32'd0);
      check("rst_dat", {24'd0, wb_bus.wb_dat_o}, 32'd0);
      check("rst_ovf", {31'd0, rx_overflow}, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      reset = 1'b0;

      // Empty FIFO
      rd_chk("status_empty", 2'd1, 8'h00);
      rd_chk("rx_empty", 2'd0, 8'h00);
      rd_chk("status_after_empty_rd", 2'd1, 8'h00);
      rd_chk("ctrl_read_zero", 2'd2, 8'h00);

      // Held valid gives exactly one token
      @(negedge clk);
      port_valid = 1'b1;
      port_data  = 8'hA5;
      repeat (10) @(negedge clk);
      port_valid = 1'b0;
      $display("token data=a5 held 10 cycles");
      rd_chk("status_one", 2'd1, 8'h09);
      rd_chk("rx_a5", 2'd0, 8'hA5);
      rd_chk("status_drained", 2'd1, 8'h00);

      // Overflow: fifth token dropped
      for (int i = 1; i <= 5; i++) token(8'(i));
      repeat (3) @(negedge clk);
      rd_chk("status_full_ovf", 2'd1, 8'h3C);
      check("ovf_flag", {31'd0, rx_overflow}, 32'd1);
      for (int i = 1; i <= 4; i++) rd_chk("rx_order", 2'd0, 8'(i));
      rd_chk("status_ovf_only", 2'd1, 8'h20);
      wr(2'd1, 8'hFF);
      rd_chk("status_wr_ignored", 2'd1, 8'h20);
      wr(2'd2, 8'h01);
      check("ovf_cleared", {31'd0, rx_overflow}, 32'd0);
      rd_chk("status_cleared", 2'd1, 8'h00);

      // Push while full on the same edge as a pop
      for (int i = 1; i <= 4; i++) token(8'h20 + 8'(i));
      repeat (3) @(negedge clk);
      rd_chk("status_full", 2'd1, 8'h1C);
      @(negedge clk);
      port_valid = 1'b1;
      port_data  = 8'h25;
      @(negedge clk);
      port_valid      = 1'b0;
      wb_bus.wb_cyc_i = 1'b1;
      wb_bus.wb_stb_i = 1'b1;
      wb_bus.wb_we_i  = 1'b0;
      wb_bus.wb_adr_i = 2'd0;
      @(negedge clk);
      check("same_edge_ack", {31'd0, wb_bus.wb_ack_o}, 32'd1);
      check("same_edge_data", {24'd0, wb_bus.wb_dat_o}, 32'h21);
      $display("read  adr=0 data=%02h expected=21 (with same-edge push 25)", wb_bus.wb_dat_o);
      wb_bus.wb_cyc_i = 1'b0;
      wb_bus.wb_stb_i = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("status_still_full", 2'd1, 8'h1C);
      check("same_edge_no_ovf", {31'd0, rx_overflow}, 32'd0);
      for (int i = 2; i <= 5; i++) rd_chk("rx_same_edge_order", 2'd0, 8'h20 + 8'(i));

      // Pointer wrap
      for (int i = 0; i < 10; i++) begin
         token(8'h10 + 8'(i));
         @(negedge clk);
         rd_chk("wrap_status", 2'd1, 8'h09);
         rd_chk("wrap_data", 2'd0, 8'h10 + 8'(i));
      end
      rd_chk("wrap_empty", 2'd1, 8'h00);

`ifdef INPORT_RX_IRQ_EN
      wr(2'd3, 8'h01);
      rd_chk("irq_en_rb", 2'd3, 8'h01);
      token(8'h77);
      check("irq_low_early", {31'd0, irq_o}, 32'd0);
      repeat (2) @(negedge clk);
      check("irq_data_set", {31'd0, irq_o}, 32'd1);
      rd_chk("irq_pop", 2'd0, 8'h77);
      @(negedge clk);
      check("irq_data_clr", {31'd0, irq_o}, 32'd0);
      wr(2'd3, 8'h00);
`else
      wr(2'd3, 8'h03);
      rd_chk("irq_en_absent", 2'd3, 8'h00);
      token(8'h77);
      repeat (3) @(negedge clk);
      check("irq_tied_low", {31'd0, irq_o}, 32'd0);
      rd_chk("rx_77", 2'd0, 8'h77);
`endif

      // Reset mid-access with valid held high across release
      token(8'h11);
      repeat (2) @(negedge clk);
      @(negedge clk);
      port_valid      = 1'b1;
      port_data       = 8'h5A;
      wb_bus.wb_cyc_i = 1'b1;
      wb_bus.wb_stb_i = 1'b1;
      wb_bus.wb_we_i  = 1'b0;
      wb_bus.wb_adr_i = 2'd1;
      reset           = 1'b1;
      @(negedge clk);
      check("mid_rst_ack", {31'd0, wb_bus.wb_ack_o}, 32'd0);
      check("mid_rst_dat", {24'd0, wb_bus.wb_dat_o}, 32'd0);
      reset           = 1'b0;
      wb_bus.wb_cyc_i = 1'b0;
      wb_bus.wb_stb_i = 1'b0;
      $display("reset mid-access, valid held with 5a");
      repeat (4) @(negedge clk);
      port_valid = 1'b0;
      rd_chk("status_post_rst", 2'd1, 8'h09);
      rd_chk("rx_post_rst", 2'd0, 8'h5A);
      rd_chk("status_post_rst_empty", 2'd1, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
